bp_be_vcache_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the BE victim cache. Shares the single vcache port between two requesters:

---
 rtl/bp_be_vcache_pkg.sv | 19 +
 rtl/bp_be_vcache_ctrl_if.sv | 37 +++
 rtl/bp_be_vcache_ctrl_arb.sv | 53 +++++
 rtl/bp_be_vcache_ctrl.sv | 132 +++++++++++++
 tb/tb_bp_be_vcache_ctrl.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_vcache_pkg.sv
// Shared types and constants for the BE victim-cache controller.
package bp_be_vcache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEvict,
        StProbe,
        StCapture,
        StResp
    } bp_be_vcache_ctrl_state_e;

    localparam int unsigned StatWidth = 16;

    function automatic int unsigned vcache_tag_width(input int unsigned addr_w,
                                                     input int unsigned depth);
        return addr_w - $clog2(depth);
    endfunction

endpackage

// File: rtl/bp_be_vcache_ctrl_if.sv
// Request/response and vcache-port bundle; signal suffixes are from the controller's point of view.
interface bp_be_vcache_ctrl_if #(
    parameter int unsigned block_width_p = 512,
    parameter int unsigned tag_width_p   = 30
);
    logic                     evict_v_i;
    logic [tag_width_p-1:0]   evict_tag_i;
    logic [block_width_p-1:0] evict_data_i;
    logic                     evict_yumi_o;
    logic                     lookup_v_i;
    logic [tag_width_p-1:0]   lookup_tag_i;
    logic                     lookup_yumi_o;
    logic                     resp_v_o;
    logic                     resp_hit_o;
    logic [block_width_p-1:0] resp_data_o;
    logic                     resp_yumi_i;
    logic                     vc_data_v_o;
    logic [block_width_p-1:0] vc_data_o;
    logic                     vc_tag_v_o;
    logic [tag_width_p-1:0]   vc_tag_o;
    logic                     vc_v_i;
    logic [block_width_p-1:0] vc_data_i;

    modport slave (
        input  evict_v_i, evict_tag_i, evict_data_i, lookup_v_i, lookup_tag_i, resp_yumi_i,
               vc_v_i, vc_data_i,
        output evict_yumi_o, lookup_yumi_o, resp_v_o, resp_hit_o, resp_data_o,
               vc_data_v_o, vc_data_o, vc_tag_v_o, vc_tag_o
    );

    modport master (
        output evict_v_i, evict_tag_i, evict_data_i, lookup_v_i, lookup_tag_i, resp_yumi_i,
               vc_v_i, vc_data_i,
        input  evict_yumi_o, lookup_yumi_o, resp_v_o, resp_hit_o, resp_data_o,
               vc_data_v_o, vc_data_o, vc_tag_v_o, vc_tag_o
    );
endinterface

// File: rtl/bp_be_vcache_ctrl_arb.sv
// Idle-state grant logic between evictions and miss lookups, with a bounded eviction-deferral count.
module bp_be_vcache_ctrl_arb #(
    parameter int unsigned tag_width_p = 30,
    parameter int unsigned max_defer_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   idle_i,
    input  logic                   evict_v_i,
    input  logic [tag_width_p-1:0] evict_tag_i,
    input  logic                   lookup_v_i,
    input  logic [tag_width_p-1:0] lookup_tag_i,
    output logic                   grant_evict_o,
    output logic                   grant_lookup_o
);
    localparam int unsigned CntW = $clog2(max_defer_p + 1);

    logic [CntW-1:0] defer_cnt_q, defer_cnt_d;
    logic            defer_full;

    assign defer_full = (defer_cnt_q == CntW'(max_defer_p));

    always_comb begin
        grant_evict_o  = 1'b0;
        grant_lookup_o = 1'b0;
        defer_cnt_d    = defer_cnt_q;
        if (idle_i) begin
            // Same tag must be written first so the lookup sees the block being evicted.
            if (evict_v_i && lookup_v_i && (evict_tag_i == lookup_tag_i)) begin
                grant_evict_o = 1'b1;
            end else if (evict_v_i && defer_full) begin
                grant_evict_o = 1'b1;
            end else if (lookup_v_i) begin
                grant_lookup_o = 1'b1;
            end else if (evict_v_i) begin
                grant_evict_o = 1'b1;
            end
        end
        if (!evict_v_i || grant_evict_o) begin
            defer_cnt_d = '0;
        end else if (grant_lookup_o && !defer_full) begin
            defer_cnt_d = defer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            defer_cnt_q <= '0;
        end else begin
            defer_cnt_q <= defer_cnt_d;
        end
    end
endmodule

// File: rtl/bp_be_vcache_ctrl.sv
// Victim-cache sequencer: shares the vcache port between evictions and miss lookups.
// Optional hit/miss counters are built when BP_BE_VCACHE_CTRL_STATS_EN is defined.
module bp_be_vcache_ctrl
    import bp_be_vcache_pkg::*;
#(
    parameter int unsigned vcache_depth_p     = 4,
    parameter int unsigned block_width_p      = 512,
    parameter int unsigned address_width_p    = 32,
    parameter int unsigned vcache_tag_width_p = vcache_tag_width(address_width_p, vcache_depth_p),
    parameter int unsigned max_defer_p        = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_be_vcache_ctrl_if.slave    bus
`ifdef BP_BE_VCACHE_CTRL_STATS_EN
    ,
    output logic [StatWidth-1:0]  hit_count_o,
    output logic [StatWidth-1:0]  miss_count_o
`endif
);
    bp_be_vcache_ctrl_state_e      state_q, state_d;
    logic [vcache_tag_width_p-1:0] tag_q, tag_d;
    logic [block_width_p-1:0]      data_q, data_d;
    logic [block_width_p-1:0]      resp_data_q, resp_data_d;
    logic                          resp_hit_q, resp_hit_d;
    logic                          grant_evict, grant_lookup;
    logic                          vc_tag_v, vc_data_v, resp_v;

    bp_be_vcache_ctrl_arb #(
        .tag_width_p (vcache_tag_width_p),
        .max_defer_p (max_defer_p)
    ) arb (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .idle_i         ((state_q == StIdle) && !reset_i),
        .evict_v_i      (bus.evict_v_i),
        .evict_tag_i    (bus.evict_tag_i),
        .lookup_v_i     (bus.lookup_v_i),
        .lookup_tag_i   (bus.lookup_tag_i),
        .grant_evict_o  (grant_evict),
        .grant_lookup_o (grant_lookup)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        data_d      = data_q;
        resp_hit_d  = resp_hit_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant_evict) begin
                    tag_d   = bus.evict_tag_i;
                    data_d  = bus.evict_data_i;
                    state_d = StEvict;
                end else if (grant_lookup) begin
                    tag_d   = bus.lookup_tag_i;
                    state_d = StProbe;
                end
            end
            StEvict: state_d = StIdle;
            StProbe: state_d = StCapture;
            // The vcache result is registered, so it is only meaningful one cycle after the probe.
            StCapture: begin
                resp_hit_d  = bus.vc_v_i;
                resp_data_d = bus.vc_v_i ? bus.vc_data_i : '0;
                state_d     = StResp;
            end
            StResp: if (bus.resp_yumi_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            tag_q       <= '0;
            data_q      <= '0;
            resp_hit_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            resp_hit_q  <= resp_hit_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign vc_data_v = (state_q == StEvict);
    assign vc_tag_v  = (state_q == StEvict) || (state_q == StProbe);
    assign resp_v    = (state_q == StResp);

    assign bus.evict_yumi_o  = grant_evict;
    assign bus.lookup_yumi_o = grant_lookup;
    assign bus.vc_data_v_o   = vc_data_v;
    assign bus.vc_data_o     = vc_data_v ? data_q : '0;
    assign bus.vc_tag_v_o    = vc_tag_v;
    assign bus.vc_tag_o      = vc_tag_v ? tag_q : '0;
    assign bus.resp_v_o      = resp_v;
    assign bus.resp_hit_o    = resp_v & resp_hit_q;
    assign bus.resp_data_o   = resp_v ? resp_data_q : '0;

`ifdef BP_BE_VCACHE_CTRL_STATS_EN
    logic [StatWidth-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StCapture) begin
            if (bus.vc_v_i) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_bp_be_vcache_ctrl.sv
// Self-checking bench for bp_be_vcache_ctrl with a behavioural victim-cache model on the vc port.
module tb_bp_be_vcache_ctrl;
    import bp_be_vcache_pkg::*;

    localparam int unsigned BlockW   = 512;
    localparam int unsigned AddrW    = 32;
    localparam int unsigned Depth    = 4;
    localparam int unsigned TagW     = AddrW - $clog2(Depth);
    localparam int unsigned MaxDefer = 4;

    typedef logic [BlockW-1:0] blk_t;
    typedef logic [TagW-1:0]   tag_t;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_checks;
    int   n_fails;

    always #5 clk_i = ~clk_i;

    bp_be_vcache_ctrl_if #(.block_width_p(BlockW), .tag_width_p(TagW)) bus ();

`ifdef BP_BE_VCACHE_CTRL_STATS_EN
    logic [StatWidth-1:0] hit_count, miss_count;
`endif

    bp_be_vcache_ctrl #(
        .vcache_depth_p  (Depth),
        .block_width_p   (BlockW),
        .address_width_p (AddrW),
        .max_defer_p     (MaxDefer)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
`ifdef BP_BE_VCACHE_CTRL_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    // Victim cache stand-in: writes on tag+data valid, registered probe result, noise otherwise.
    blk_t       vc_mem [256];
    logic [255:0] vc_has = '0;
    logic       vc_v_r = 1'b0;
    blk_t       vc_data_r = '0;
    assign bus.vc_v_i    = vc_v_r;
    assign bus.vc_data_i = vc_data_r;

    always @(posedge clk_i) begin
        if (bus.vc_tag_v_o && bus.vc_data_v_o) begin
            vc_mem[bus.vc_tag_o[7:0]] <= bus.vc_data_o;
            vc_has[bus.vc_tag_o[7:0]] <= 1'b1;
            vc_v_r    <= 1'b1;
            vc_data_r <= ~bus.vc_data_o;
        end else if (bus.vc_tag_v_o) begin
            vc_v_r    <= vc_has[bus.vc_tag_o[7:0]];
            vc_data_r <= vc_has[bus.vc_tag_o[7:0]] ? vc_mem[bus.vc_tag_o[7:0]]
                                                   : {16{32'hDEAD_BEEF}};
        end else begin
            vc_v_r    <= 1'($urandom_range(0, 1));
            vc_data_r <= {16{$urandom()}};
        end
    end

    // Reference: last block evicted for each tag.
    blk_t ref_mem [tag_t];

    task automatic do_evict(input tag_t tag, input blk_t data, output bit acc);
        @(negedge clk_i);
        bus.evict_v_i = 1'b1;
        bus.evict_tag_i = tag;
        bus.evict_data_i = data;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (bus.evict_yumi_o) acc = 1'b1;
            else @(negedge clk_i);
        end
        @(negedge clk_i);
        bus.evict_v_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic run_lookup(input tag_t tag, input int hold, output bit acc, output int lat,
                              output bit hit, output blk_t data);
        @(negedge clk_i);
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = tag;
        acc = 1'b0;
        lat = -1;
        hit = 1'b0;
        data = '0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (bus.lookup_yumi_o) acc = 1'b1;
            else @(negedge clk_i);
        end
        @(negedge clk_i);
        bus.lookup_v_i = 1'b0;
        if (!acc) return;
        lat = 1;
        while (!bus.resp_v_o && lat < 20) begin
            bus.resp_yumi_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            lat++;
        end
        bus.resp_yumi_i = 1'b0;
        if (!bus.resp_v_o) begin
            lat = -1;
            return;
        end
        hit = bus.resp_hit_o;
        data = bus.resp_data_o;
        repeat (hold) @(negedge clk_i);
        bus.resp_yumi_i = 1'b1;
        @(negedge clk_i);
        bus.resp_yumi_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            bus.resp_yumi_i = bus.resp_v_o;
        end
        bus.resp_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        bus.evict_v_i = 1'b1;
        bus.evict_tag_i = 'h10;
        bus.evict_data_i = {16{32'h1111_2222}};
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h11;
        bus.resp_yumi_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if ({bus.evict_yumi_o, bus.lookup_yumi_o} !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_yumi: got %b required 00", {bus.evict_yumi_o, bus.lookup_yumi_o});
        end
        n_checks++;
        if ({bus.resp_v_o, bus.resp_hit_o, bus.vc_data_v_o, bus.vc_tag_v_o} !== 4'b0) begin
            n_fails++;
            $display("FAIL reset_valids: got %b required 0000",
                     {bus.resp_v_o, bus.resp_hit_o, bus.vc_data_v_o, bus.vc_tag_v_o});
        end
        n_checks++;
        if (bus.resp_data_o !== '0 || bus.vc_data_o !== '0 || bus.vc_tag_o !== '0) begin
            n_fails++;
            $display("FAIL reset_buses: got vc_tag %0h required 0 (data buses must be 0 too)",
                     bus.vc_tag_o);
        end
        bus.evict_v_i = 1'b0;
        bus.lookup_v_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({bus.resp_v_o, bus.vc_tag_v_o, bus.evict_yumi_o, bus.lookup_yumi_o} !== 4'b0) begin
            n_fails++;
            $display("FAIL post_reset_idle: got %b required 0000",
                     {bus.resp_v_o, bus.vc_tag_v_o, bus.evict_yumi_o, bus.lookup_yumi_o});
        end
    endtask

    task automatic test_evict_hit();
        blk_t d = {64{8'hAB}};
        int   lat;
        @(negedge clk_i);
        bus.evict_v_i = 1'b1;
        bus.evict_tag_i = 'h1A;
        bus.evict_data_i = d;
        #1;
        n_checks++;
        if ({bus.evict_yumi_o, bus.lookup_yumi_o} !== 2'b10) begin
            n_fails++;
            $display("FAIL evict_accept: got %b required 10", {bus.evict_yumi_o, bus.lookup_yumi_o});
        end
        ref_mem['h1A] = d;
        @(negedge clk_i);
        bus.evict_v_i = 1'b0;
        n_checks++;
        if (bus.vc_data_v_o !== 1'b1 || bus.vc_tag_v_o !== 1'b1 || bus.vc_tag_o !== tag_t'('h1A)
            || bus.vc_data_o !== d) begin
            n_fails++;
            $display("FAIL evict_write: got v %b%b tag %0h required 11 tag 1a",
                     bus.vc_data_v_o, bus.vc_tag_v_o, bus.vc_tag_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({bus.vc_data_v_o, bus.vc_tag_v_o} !== 2'b00 || bus.vc_tag_o !== '0
            || bus.vc_data_o !== '0) begin
            n_fails++;
            $display("FAIL evict_done: got v %b%b tag %0h required 00 tag 0",
                     bus.vc_data_v_o, bus.vc_tag_v_o, bus.vc_tag_o);
        end
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h1A;
        #1;
        n_checks++;
        if (bus.lookup_yumi_o !== 1'b1) begin
            n_fails++;
            $display("FAIL lookup_accept: got %b required 1", bus.lookup_yumi_o);
        end
        @(negedge clk_i);
        bus.lookup_v_i = 1'b0;
        n_checks++;
        if ({bus.vc_tag_v_o, bus.vc_data_v_o} !== 2'b10 || bus.vc_tag_o !== tag_t'('h1A)
            || bus.vc_data_o !== '0) begin
            n_fails++;
            $display("FAIL probe_drive: got v %b%b tag %0h required 10 tag 1a",
                     bus.vc_tag_v_o, bus.vc_data_v_o, bus.vc_tag_o);
        end
        lat = 1;
        while (!bus.resp_v_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        n_checks++;
        if (lat != 3 || bus.resp_hit_o !== 1'b1 || bus.resp_data_o !== ref_mem['h1A]) begin
            n_fails++;
            $display("FAIL evict_then_hit: got latency %0d hit %b data %0h required 3 1 %0h",
                     lat, bus.resp_hit_o, bus.resp_data_o[31:0], ref_mem['h1A][31:0]);
        end
        bus.resp_yumi_i = 1'b1;
        @(negedge clk_i);
        bus.resp_yumi_i = 1'b0;
        n_checks++;
        if (bus.resp_v_o !== 1'b0) begin
            n_fails++;
            $display("FAIL resp_release: got %b required 0", bus.resp_v_o);
        end
    endtask

    task automatic test_miss_hold();
        int   lat;
        bit   stable = 1'b1;
        bit   no_accept = 1'b1;
        bit   exp_hit = ref_mem.exists('h2F);
        blk_t exp_data = exp_hit ? ref_mem['h2F] : '0;
        @(negedge clk_i);
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h2F;
        #1;
        n_checks++;
        if (bus.lookup_yumi_o !== 1'b1) begin
            n_fails++;
            $display("FAIL miss_accept: got %b required 1", bus.lookup_yumi_o);
        end
        @(negedge clk_i);
        bus.lookup_v_i = 1'b0;
        lat = 1;
        while (!bus.resp_v_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        n_checks++;
        if (lat != 3 || bus.resp_hit_o !== exp_hit || bus.resp_data_o !== exp_data) begin
            n_fails++;
            $display("FAIL miss_resp: got latency %0d hit %b data %0h required 3 %b 0",
                     lat, bus.resp_hit_o, bus.resp_data_o[31:0], exp_hit);
        end
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1;
            if (bus.resp_v_o !== 1'b1 || bus.resp_hit_o !== exp_hit
                || bus.resp_data_o !== exp_data) stable = 1'b0;
            if (bus.lookup_yumi_o !== 1'b0) no_accept = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fails++;
            $display("FAIL resp_hold: got unstable response required stable for 5 cycles");
        end
        n_checks++;
        if (!no_accept) begin
            n_fails++;
            $display("FAIL busy_accept: got lookup_yumi during RESP required none");
        end
        bus.lookup_v_i = 1'b0;
        bus.resp_yumi_i = 1'b1;
        @(negedge clk_i);
        bus.resp_yumi_i = 1'b0;
        n_checks++;
        if (bus.resp_v_o !== 1'b0) begin
            n_fails++;
            $display("FAIL miss_release: got %b required 0", bus.resp_v_o);
        end
    endtask

    task automatic test_defer();
        string got = "";
        string exp = "";
        int    cnt = 0;
        blk_t  d = {16{32'h0505_F00D}};
        for (int k = 0; k < 5; k++) begin
            if (cnt == int'(MaxDefer)) begin
                exp = {exp, "E"};
                cnt = 0;
            end else begin
                exp = {exp, "L"};
                cnt++;
            end
        end
        @(negedge clk_i);
        bus.evict_v_i = 1'b1;
        bus.evict_tag_i = 'h05;
        bus.evict_data_i = d;
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h06;
        for (int cyc = 0; cyc < 100 && got.len() < 5; cyc++) begin
            #1;
            if (bus.evict_yumi_o && bus.lookup_yumi_o) got = {got, "X"};
            else if (bus.evict_yumi_o) got = {got, "E"};
            else if (bus.lookup_yumi_o) got = {got, "L"};
            bus.resp_yumi_i = bus.resp_v_o;
            if (got.len() < 5) @(negedge clk_i);
        end
        @(negedge clk_i);
        bus.evict_v_i = 1'b0;
        bus.lookup_v_i = 1'b0;
        bus.resp_yumi_i = 1'b0;
        drain();
        ref_mem['h05] = d;
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL defer_order: got %s required %s", got, exp);
        end
    endtask

    task automatic test_same_tag();
        blk_t d = {16{32'h3333_C0DE}};
        int   lat;
        @(negedge clk_i);
        bus.evict_v_i = 1'b1;
        bus.evict_tag_i = 'h33;
        bus.evict_data_i = d;
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h33;
        #1;
        n_checks++;
        if ({bus.evict_yumi_o, bus.lookup_yumi_o} !== 2'b10) begin
            n_fails++;
            $display("FAIL same_tag_order: got %b required 10", {bus.evict_yumi_o, bus.lookup_yumi_o});
        end
        ref_mem['h33] = d;
        @(negedge clk_i);
        bus.evict_v_i = 1'b0;
        #1;
        n_checks++;
        if (bus.lookup_yumi_o !== 1'b0) begin
            n_fails++;
            $display("FAIL evict_busy: got lookup_yumi %b required 0", bus.lookup_yumi_o);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (bus.lookup_yumi_o !== 1'b1) begin
            n_fails++;
            $display("FAIL same_tag_lookup: got lookup_yumi %b required 1", bus.lookup_yumi_o);
        end
        @(negedge clk_i);
        bus.lookup_v_i = 1'b0;
        lat = 1;
        while (!bus.resp_v_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        n_checks++;
        if (lat != 3 || bus.resp_hit_o !== 1'b1 || bus.resp_data_o !== ref_mem['h33]) begin
            n_fails++;
            $display("FAIL same_tag_hit: got latency %0d hit %b data %0h required 3 1 %0h",
                     lat, bus.resp_hit_o, bus.resp_data_o[31:0], ref_mem['h33][31:0]);
        end
        bus.resp_yumi_i = 1'b1;
        @(negedge clk_i);
        bus.resp_yumi_i = 1'b0;
    endtask

    task automatic test_random();
        tag_t t;
        blk_t d, data, exp_data;
        bit   acc, hit, exp_hit;
        int   lat;
        for (int k = 0; k < 30; k++) begin
            t = tag_t'(8'h40 + 8'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) begin
                d = {16{$urandom()}};
                do_evict(t, d, acc);
                ref_mem[t] = d;
                n_checks++;
                if (!acc) begin
                    n_fails++;
                    $display("FAIL rand_evict: got no accept for tag %0h required accept", t);
                end
            end else begin
                run_lookup(t, $urandom_range(0, 3), acc, lat, hit, data);
                exp_hit = ref_mem.exists(t);
                exp_data = exp_hit ? ref_mem[t] : '0;
                n_checks++;
                if (!acc || lat != 3 || hit !== exp_hit || data !== exp_data) begin
                    n_fails++;
                    $display("FAIL rand_lookup: tag %0h got acc %b lat %0d hit %b data %0h required 1 3 %b %0h",
                             t, acc, lat, hit, data[31:0], exp_hit, exp_data[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_probe();
        bit   seen = 1'b0;
        bit   acc, hit;
        int   lat;
        blk_t data;
        @(negedge clk_i);
        bus.lookup_v_i = 1'b1;
        bus.lookup_tag_i = 'h1A;
        #1;
        n_checks++;
        if (bus.lookup_yumi_o !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_accept: got %b required 1", bus.lookup_yumi_o);
        end
        @(negedge clk_i);
        bus.lookup_v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if ({bus.vc_tag_v_o, bus.resp_v_o} !== 2'b00) begin
            n_fails++;
            $display("FAIL async_reset: got %b required 00", {bus.vc_tag_v_o, bus.resp_v_o});
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        n_checks++;
        if ({bus.vc_tag_v_o, bus.resp_v_o} !== 2'b00) begin
            n_fails++;
            $display("FAIL mid_reset_idle: got %b required 00", {bus.vc_tag_v_o, bus.resp_v_o});
        end
        repeat (8) begin
            @(negedge clk_i);
            if (bus.resp_v_o || bus.vc_tag_v_o) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fails++;
            $display("FAIL dropped_lookup: got late activity required none");
        end
        run_lookup('h1A, 0, acc, lat, hit, data);
        n_checks++;
        if (!acc || lat != 3 || hit !== 1'b1 || data !== ref_mem['h1A]) begin
            n_fails++;
            $display("FAIL post_reset_lookup: got acc %b lat %0d hit %b required 1 3 1", acc, lat, hit);
        end
    endtask

`ifdef BP_BE_VCACHE_CTRL_STATS_EN
    task automatic test_stats();
        tag_t tags [5] = '{'h1A, 'h2F, 'h33, 'h77, 'h05};
        int   eh = 0;
        int   em = 0;
        bit   acc, hit;
        int   lat;
        blk_t data;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_lookup(tags[i], 0, acc, lat, hit, data);
            if (ref_mem.exists(tags[i])) eh++;
            else em++;
        end
        n_checks++;
        if (int'(hit_count) != eh || int'(miss_count) != em) begin
            n_fails++;
            $display("FAIL stats_count: got %0d/%0d required %0d/%0d", hit_count, miss_count, eh, em);
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (hit_count !== '0 || miss_count !== '0) begin
            n_fails++;
            $display("FAIL stats_reset: got %0d/%0d required 0/0", hit_count, miss_count);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fails = 0;
        bus.evict_v_i = 1'b0;
        bus.evict_tag_i = '0;
        bus.evict_data_i = '0;
        bus.lookup_v_i = 1'b0;
        bus.lookup_tag_i = '0;
        bus.resp_yumi_i = 1'b0;
        test_reset();
        test_evict_hit();
        test_miss_hold();
        test_defer();
        test_same_tag();
        test_random();
        test_reset_mid_probe();
`ifdef BP_BE_VCACHE_CTRL_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
